// File: rtl/filtr_wejsc.sv
// Input conditioning for one PLC input port: two-flop synchroniser, per-bit
// tick-based debounce, sticky rise/fall flags and a port-wide change pulse.

module filtr_wejsc_lane #(
    parameter int DEB_CYCLES = 16,
    parameter int CNT_W      = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    input  logic en_tick,
    input  logic clr,
    output logic out,
    output logic rise,
    output logic fall,
    output logic flip
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEB_CYCLES - 1);

    logic             s1, s2;
    logic [CNT_W-1:0] cnt;

    // The accepting tick is the one where a full run of disagreeing samples completes.
    assign flip = en_tick && (s2 != out) && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            cnt  <= '0;
            out  <= 1'b0;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            if (en_tick) begin
                if (s2 == out) begin
                    cnt <= '0;
                end else if (cnt == LAST) begin
                    out <= s2;
                    cnt <= '0;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
            // A new edge outranks a simultaneous clear so no event is lost.
            if (flip && s2)
                rise <= 1'b1;
            else if (clr)
                rise <= 1'b0;
            if (flip && !s2)
                fall <= 1'b1;
            else if (clr)
                fall <= 1'b0;
        end
    end
endmodule

module filtr_wejsc #(
    parameter int WIDTH      = 8,
    parameter int DEB_CYCLES = 16,
    parameter int CNT_W      = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] raw_in,
    input  logic             en_tick,
    input  logic [WIDTH-1:0] clr_edges,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             changed
);
    logic [WIDTH-1:0] flips;

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        filtr_wejsc_lane #(
            .DEB_CYCLES(DEB_CYCLES),
            .CNT_W     (CNT_W)
        ) u_lane (
            .clk    (clk),
            .rst_n  (rst_n),
            .raw    (raw_in[i]),
            .en_tick(en_tick),
            .clr    (clr_edges[i]),
            .out    (out[i]),
            .rise   (rise[i]),
            .fall   (fall[i]),
            .flip   (flips[i])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            changed <= 1'b0;
        else
            changed <= |flips;
    end
endmodule
